// File: rtl/pwm_pkg.sv
// pwm_gen shared definitions: alignment modes, function bits,
// dead-time FSM state encoding.
package pwm_pkg;

  localparam logic [1:0] PWM_ALIGN_LEFT  = 2'b00;
  localparam logic [1:0] PWM_ALIGN_RIGHT = 2'b01;
  localparam logic [1:0] PWM_UNALIGNED   = 2'b1x;

  localparam int FN_INV_BIT = 2;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    ON_H = 2'd2,
    ON_L = 2'd3
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion between pwm_out and pwm_out_n; a zero
// dead-time is a combinational complement with no extra latency.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            p,
  input  logic [DT_W-1:0] deadtime,
  output logic            pwm_out,
  output logic            pwm_out_n
);

  dt_state_e       state, state_nx;
  logic [DT_W-1:0] cnt, cnt_nx;
  logic            side, side_nx;
  logic            start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
      side  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      side  <= side_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    side_nx   = side;
    pwm_out   = 1'b0;
    pwm_out_n = 1'b0;
    start     = 1'b0;
    if (!en) begin
      state_nx = OFF;
    end else if (deadtime == '0) begin
      pwm_out   = p;
      pwm_out_n = !p;
      side_nx   = p;
      state_nx  = p ? ON_H : ON_L;
    end else begin
      unique case (state)
        OFF: start = 1'b1;
        DEAD: begin
          if (p != side) begin
            start = 1'b1;
          end else if (cnt == '0) begin
            pwm_out   = side;
            pwm_out_n = !side;
            state_nx  = side ? ON_H : ON_L;
          end else begin
            cnt_nx = cnt - DT_W'(1);
          end
        end
        ON_H: begin
          if (!p) start = 1'b1;
          else pwm_out = 1'b1;
        end
        ON_L: begin
          if (p) start = 1'b1;
          else pwm_out_n = 1'b1;
        end
        default: state_nx = OFF;
      endcase
      // every edge of p (or enable) opens a fresh dead interval
      if (start) begin
        state_nx = DEAD;
        side_nx  = p;
        cnt_nx   = deadtime - DT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM compare/output stage with period-boundary shadow registers.
// Optional dead-time complementary output: PWM_DEADTIME_EN.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DT_W  = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_en,
  input  logic [CNT_W-1:0] count_val,
  input  logic [CNT_W-1:0] period,
  input  logic             upnotdown,
  input  logic [CNT_W-1:0] compare1,
  input  logic [CNT_W-1:0] compare2,
  input  logic [2:0]       functions,
`ifdef PWM_DEADTIME_EN
  input  logic [DT_W-1:0]  deadtime,
  output logic             pwm_out_n,
`endif
  output logic             pwm_out,
  output logic             period_done
);

  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] prev_cnt;
  logic [CNT_W-1:0] act_c1, act_c2;
  logic [CNT_W-1:0] c1, c2;
  logic [2:0]       act_fn, fn;
  logic             en_d;
  logic             boundary, load;
  logic             raw, p;

  always_comb begin
    pos      = upnotdown ? count_val : period - count_val;
    boundary = (count_val != prev_cnt) && (pos == '0);
    load     = boundary || (pwm_en && !en_d);
    // the loading cycle already compares against the new values
    c1       = load ? compare1  : act_c1;
    c2       = load ? compare2  : act_c2;
    fn       = load ? functions : act_fn;
  end

  always_comb begin
    raw = 1'b0;
    unique case (1'b1)
      (fn[1:0] ==? PWM_UNALIGNED):   raw = (c1 <= pos) && (pos < c2);
      (fn[1:0] == PWM_ALIGN_RIGHT): raw = pos >= c1;
      default:                      raw = pos < c1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt    <= '0;
      act_c1      <= '0;
      act_c2      <= '0;
      act_fn      <= '0;
      en_d        <= 1'b0;
      p           <= 1'b0;
      period_done <= 1'b0;
    end else begin
      prev_cnt    <= count_val;
      en_d        <= pwm_en;
      period_done <= boundary;
      p           <= pwm_en & (raw ^ fn[FN_INV_BIT]);
      if (load) begin
        act_c1 <= compare1;
        act_c2 <= compare2;
        act_fn <= functions;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DT_W (DT_W)
  ) u_dt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_d),
    .p         (p),
    .deadtime  (deadtime),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n)
  );
`else
  assign pwm_out = p;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen.
// Covers alignment modes, shadow timing, edge cases, async reset.
module tb_pwm_gen;

  logic        clk;
  logic        rst_n;
  logic        pwm_en;
  logic [15:0] count_val;
  logic [15:0] period;
  logic        upnotdown;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [2:0]  functions;
  logic        pwm_out;
  logic        period_done;
`ifdef PWM_DEADTIME_EN
  logic [7:0]  deadtime;
  logic        pwm_out_n;
`endif

  int tests = 0;
  int fails = 0;

  pwm_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_en      (pwm_en),
    .count_val   (count_val),
    .period      (period),
    .upnotdown   (upnotdown),
    .compare1    (compare1),
    .compare2    (compare2),
    .functions   (functions),
`ifdef PWM_DEADTIME_EN
    .deadtime    (deadtime),
    .pwm_out_n   (pwm_out_n),
`endif
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] cnt, input logic e_out,
                     input logic e_pd, input string tag);
    count_val = cnt;
    @(posedge clk);
    #1;
    chk({tag, "_out"}, pwm_out, e_out);
    chk({tag, "_pd"}, period_done, e_pd);
  endtask

  task automatic run_period(input logic [9:0] pat,
                            input logic first_pd,
                            input int presc, input int wr_at,
                            input logic [15:0] wr_val,
                            input string tag);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < presc; k++) begin
        if (i == wr_at && k == 0) compare1 = wr_val;
        cyc(upnotdown ? 16'(i) : 16'(9 - i), pat[i],
            (i == 0 && k == 0) ? first_pd : 1'b0,
            $sformatf("%s_p%0d", tag, i));
      end
    end
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic dcyc(input logic [15:0] cnt, input logic eo,
                      input logic en, input string tag);
    count_val = cnt;
    @(posedge clk);
    #1;
    chk({tag, "_out"}, pwm_out, eo);
    chk({tag, "_outn"}, pwm_out_n, en);
    chk({tag, "_excl"}, pwm_out & pwm_out_n, 1'b0);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    pwm_en    = 1'b0;
    count_val = 16'd0;
    period    = 16'd9;
    upnotdown = 1'b1;
    compare1  = 16'd3;
    compare2  = 16'd0;
    functions = 3'b000;
`ifdef PWM_DEADTIME_EN
    deadtime  = 8'd0;
`endif
    #12;
    chk("rst_out", pwm_out, 1'b0);
    chk("rst_pd", period_done, 1'b0);
`ifdef PWM_DEADTIME_EN
    chk("rst_outn", pwm_out_n, 1'b0);
`endif
    rst_n  = 1'b1;
    pwm_en = 1'b1;

    run_period(10'b0000000111, 1'b0, 1, -1, 16'd0, "left3a");
    run_period(10'b0000000111, 1'b1, 1, -1, 16'd0, "left3b");

    functions = 3'b101;
    compare1  = 16'd7;
    run_period(10'b0001111111, 1'b1, 1, -1, 16'd0, "rinv7");

    functions = 3'b010;
    compare1  = 16'd2;
    compare2  = 16'd5;
    run_period(10'b0000011100, 1'b1, 1, -1, 16'd0, "unal25");

    functions = 3'b000;
    compare1  = 16'd3;
    run_period(10'b0000000111, 1'b1, 1, 4, 16'd6, "midwr");
    run_period(10'b0000111111, 1'b1, 1, -1, 16'd0, "left6");

    compare1 = 16'd0;
    run_period(10'b0000000000, 1'b1, 1, -1, 16'd0, "left0");
    compare1 = 16'd12;
    run_period(10'b1111111111, 1'b1, 1, -1, 16'd0, "left12");
    functions = 3'b010;
    compare1  = 16'd5;
    compare2  = 16'd5;
    run_period(10'b0000000000, 1'b1, 1, -1, 16'd0, "unal55");

    upnotdown = 1'b0;
    functions = 3'b000;
    compare1  = 16'd3;
    cyc(16'd0, 1'b0, 1'b0, "dn_pre");
    run_period(10'b0000000111, 1'b1, 3, -1, 16'd0, "dn3a");
    run_period(10'b0000000111, 1'b1, 3, -1, 16'd0, "dn3b");

    upnotdown = 1'b1;
    compare1  = 16'd12;
    cyc(16'd5, 1'b0, 1'b0, "up_pre");
    cyc(16'd0, 1'b1, 1'b1, "rs_p0");
    for (int i = 1; i < 5; i++)
      cyc(16'(i), 1'b1, 1'b0, $sformatf("rs_p%0d", i));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", pwm_out, 1'b0);
    chk("rst_mid_pd", period_done, 1'b0);
    rst_n = 1'b1;
    cyc(16'd5, 1'b1, 1'b0, "resume");
    pwm_en = 1'b0;
    cyc(16'd6, 1'b0, 1'b0, "en_fall");

`ifdef PWM_DEADTIME_EN
    begin
      logic [12:0] eo;
      logic [12:0] en;
      logic [6:0]  eo2;
      logic [6:0]  en2;
      eo  = 13'b1000000011100;
      en  = 13'b0001110000000;
      eo2 = 7'b0000011;
      en2 = 7'b1110000;
      pwm_en    = 1'b1;
      deadtime  = 8'd2;
      functions = 3'b000;
      compare1  = 16'd5;
      for (int j = 0; j < 13; j++)
        dcyc(16'(j % 10), eo[j], en[j], $sformatf("dt2_%0d", j));
      for (int j = 0; j < 7; j++)
        dcyc(16'(j + 3), eo2[j], en2[j], $sformatf("dt2t_%0d", j));
      compare1 = 16'd3;
      period   = 16'd19;
      deadtime = 8'd8;
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < 20; j++)
          dcyc(16'(j), 1'b0, (j >= 11) ? 1'b1 : 1'b0,
               $sformatf("dt8_%0d_%0d", r, j));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
